// File: rtl/usb_debug_dma_pkg.sv
// Shared types and defaults for the USB debug DMA engine.
package usb_debug_dma_pkg;

   localparam int ADDR_W_DEF = 24;
   localparam int LEN_W_DEF  = 20;
   localparam int BANK_W     = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_FILL  = 2'd1,
      ST_WRITE = 2'd2
   } state_t;

endpackage

// File: rtl/usb_debug_dma_if.sv
// RX FIFO read port plus cart memory bus write channel; master is the DMA side.
interface usb_debug_dma_if #(
   parameter int ADDR_W = 24
);
   logic                                rx_empty;
   logic [7:0]                          rx_data;
   logic                                rx_read;
   logic                                request;
   logic                                write;
   logic                                busy;
   logic [usb_debug_dma_pkg::BANK_W-1:0] bank;
   logic [ADDR_W-1:0]                   address;
   logic [31:0]                         data;

   modport master (
      input  rx_empty, rx_data, busy,
      output rx_read, request, write, bank, address, data
   );

   modport slave (
      output rx_empty, rx_data, busy,
      input  rx_read, request, write, bank, address, data
   );
endinterface

// File: rtl/usb_dma_packer.sv
// Big-endian byte packer: shifts FIFO bytes MSB-first, flags the 4th byte of a word.
module usb_dma_packer (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_clear,
   input  logic        i_pop,
   input  logic [7:0]  i_byte,
   output logic [31:0] o_word,
   output logic        o_word_ready
);

   logic [23:0] shift_q;
   logic [1:0]  byte_cnt;

   // o_word already includes the byte being popped so the FSM can register it directly.
   assign o_word       = {shift_q, i_byte};
   assign o_word_ready = i_pop && (byte_cnt == 2'd3);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         shift_q  <= '0;
         byte_cnt <= '0;
      end else if (i_clear) begin
         byte_cnt <= '0;
      end else if (i_pop) begin
         shift_q  <= o_word[23:0];
         byte_cnt <= byte_cnt + 2'd1;
      end
   end

endmodule

// File: rtl/usb_debug_dma.sv
// USB RX FIFO to SDRAM debug DMA: fill a word from 4 bytes, then write it, repeat.
// Optional USB_DEBUG_DMA_ABORT_EN adds i_dma_abort to cancel a transfer.
module usb_debug_dma
   import usb_debug_dma_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int LEN_W  = LEN_W_DEF
) (
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic              i_dma_start,
   input  logic [BANK_W-1:0] i_dma_bank,
   input  logic [ADDR_W-1:0] i_dma_address,
   input  logic [LEN_W-1:0]  i_dma_length,
`ifdef USB_DEBUG_DMA_ABORT_EN
   input  logic              i_dma_abort,
`endif
   output logic              o_dma_busy,
   output logic              o_dma_done,
   usb_debug_dma_if.master   bus
);

   state_t            state;
   logic              busy_q;
   logic              done_q;
   logic              request_q;
   logic [BANK_W-1:0] bank_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       data_q;
   logic [LEN_W-1:0]  words_left;

   logic              abort;
   logic              rx_read;
   logic              accept;
   logic              word_ready;
   logic [31:0]       packed_word;

`ifdef USB_DEBUG_DMA_ABORT_EN
   assign abort = i_dma_abort;
`else
   assign abort = 1'b0;
`endif

   // An abort cycle pops nothing, so no byte is lost from the FIFO for a discarded word.
   assign rx_read = (state == ST_FILL) && !bus.rx_empty && !abort;
   assign accept  = request_q && !bus.busy;

   usb_dma_packer u_packer (
      .i_clk        (i_clk),
      .i_reset_n    (i_reset_n),
      .i_clear      (state == ST_IDLE),
      .i_pop        (rx_read),
      .i_byte       (bus.rx_data),
      .o_word       (packed_word),
      .o_word_ready (word_ready)
   );

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state      <= ST_IDLE;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         request_q  <= 1'b0;
         bank_q     <= '0;
         addr_q     <= '0;
         data_q     <= '0;
         words_left <= '0;
      end else begin
         done_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (i_dma_start && (i_dma_length != '0)) begin
                  bank_q     <= i_dma_bank;
                  addr_q     <= i_dma_address;
                  words_left <= i_dma_length;
                  busy_q     <= 1'b1;
                  state      <= ST_FILL;
               end
            end
            ST_FILL: begin
               if (abort) begin
                  busy_q <= 1'b0;
                  state  <= ST_IDLE;
               end else if (word_ready) begin
                  data_q    <= packed_word;
                  request_q <= 1'b1;
                  state     <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               // An accepted write always advances the pointer, even when aborted alongside.
               if (accept) begin
                  addr_q     <= addr_q + ADDR_W'(1);
                  words_left <= words_left - LEN_W'(1);
                  request_q  <= 1'b0;
               end
               if (abort) begin
                  request_q <= 1'b0;
                  busy_q    <= 1'b0;
                  state     <= ST_IDLE;
               end else if (accept) begin
                  if (words_left == LEN_W'(1)) begin
                     busy_q <= 1'b0;
                     done_q <= 1'b1;
                     state  <= ST_IDLE;
                  end else begin
                     state <= ST_FILL;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign o_dma_busy  = busy_q;
   assign o_dma_done  = done_q;
   assign bus.rx_read = rx_read;
   assign bus.request = request_q;
   assign bus.write   = request_q;
   assign bus.bank    = bank_q;
   assign bus.address = addr_q;
   assign bus.data    = data_q;

endmodule

// File: doc/usb_debug_dma.md
Name: usb_debug_dma

Overview:
- DMA engine that sits on the far end of the cart control block's debug DMA outputs (start/bank/address/length).
- Drains bytes from the USB RX FIFO and packs them big-endian into 32-bit words.
- Writes those words to SDRAM through the cart memory bus as an initiator.
- Reports busy/done back to the control block for the USB status register.

Parameters:
- ADDR_W, 24, word-address width of the transfer address.
- LEN_W, 20, width of the transfer length in 32-bit words.

Ports:
- i_clk  input  1  system clock
- i_reset_n  input  1  asynchronous active-low reset
- i_dma_start  input  1  1-cycle start pulse from control block
- i_dma_bank  input  4  target bank, sampled on start
- i_dma_address  input  ADDR_W  starting word address, sampled on start
- i_dma_length  input  LEN_W  word count, sampled on start
- o_dma_busy  output  1  transfer in progress
- o_dma_done  output  1  1-cycle pulse on normal completion
- i_rx_empty  input  1  USB RX FIFO empty
- i_rx_data  input  8  FIFO head byte (first-word-fall-through, valid while !i_rx_empty)
- o_rx_read  output  1  pop FIFO head this cycle
- o_request  output  1  memory bus request
- o_write  output  1  memory bus write strobe (always equal to o_request)
- i_busy  input  1  memory bus stall
- o_bank  output  4  memory bus bank
- o_address  output  ADDR_W  memory bus word address
- o_data  output  32  memory bus write data

Behaviour:
- Reset (async, i_reset_n=0), applied immediately even mid-transfer:
  - state IDLE
  - o_dma_busy, o_dma_done, o_rx_read, o_request, o_write = 0
  - o_bank = 0, o_address = 0, o_data = 0
  - internal counters = 0
- States: IDLE, FILL, WRITE.
- IDLE:
  - On i_dma_start with i_dma_length != 0: latch bank, address and words_left = length; clear byte_cnt; go to FILL; o_dma_busy=1 from the next cycle.
  - On i_dma_start with length == 0: ignored. No busy, no FIFO reads, no done pulse.
- FILL:
  - o_rx_read = (state==FILL) && !i_rx_empty. This is combinational; a pop happens in the same cycle it is asserted.
  - Each pop shifts data in MSB-first: word <= {word[23:0], i_rx_data}; byte_cnt increments.
  - On the 4th pop (byte_cnt==3), register o_data and go to WRITE.
  - FIFO empty: wait indefinitely with no timeout.
- WRITE:
  - o_request = o_write = 1; o_bank/o_address/o_data held stable.
  - A transfer is accepted in any cycle where o_request && !i_busy.
  - On accept: o_address <= o_address+1, wrapping modulo 2^ADDR_W with bank unchanged; words_left decrements.
  - If words_left was 1: go to IDLE; o_dma_busy=0 and o_dma_done=1 in the next cycle (for one cycle).
  - Otherwise: go to FILL with byte_cnt=0.
- o_rx_read is never asserted in WRITE; there is no overlap of fill and write.
- Minimum throughput is 5 cycles per word (4 pops + 1 accept).
- i_dma_start while busy: ignored. Latched parameters are unchanged.
- The start inputs are sampled only in the cycle of the accepted start pulse; later changes have no effect.

Optional Feature:
- Macro USB_DEBUG_DMA_ABORT_EN.
- When defined:
  - Adds port i_dma_abort (input, 1).
  - When i_dma_abort=1 in FILL or WRITE: next state is IDLE, o_request drops and o_dma_busy=0 next cycle.
  - Any partial word is discarded and no done pulse is generated.
  - If the abort coincides with an accept (o_request && !i_busy), that write counts as completed on the bus, but the state machine still returns to IDLE with no done pulse.
  - Abort in IDLE: no effect. Abort with start in the same IDLE cycle: start wins.
- When undefined: no port; transfers always run to completion.

Decomposition:
- Package usb_debug_dma_pkg:
  - state enum (IDLE/FILL/WRITE)
  - ADDR_W/LEN_W defaults
  - bank width constant (4)
- One natural sub-module, usb_dma_packer: byte shift register plus byte_cnt with clear/pop inputs and a word_ready output. The rest stays in the top-level FSM.

Test Plan:
1. Single-word transfer:
   - Stimulus: start with bank=1, addr=0x000010, len=1; FIFO supplies DE AD BE EF.
   - Response: exactly one accept with o_bank=1, o_address=0x000010, o_data=0xDEADBEEF; o_dma_done pulses once; o_dma_busy returns to 0.
2. FIFO gaps:
   - Stimulus: len=3, with i_rx_empty toggling randomly.
   - Response: o_rx_read only when !i_rx_empty; 12 pops; three writes at addr, addr+1, addr+2 with correctly packed data.
3. Bus stall:
   - Stimulus: i_busy held high for 5 cycles during WRITE.
   - Response: o_request, o_address and o_data stable for all 5 cycles; exactly one accept when i_busy falls; no FIFO pops while stalled.
4. Address wrap:
   - Stimulus: addr=0xFFFFFF, bank=2, len=2.
   - Response: second write at address 0x000000 with bank still 2.
5. Ignored starts:
   - Stimulus: len=0 start; separately, a second start mid-transfer.
   - Response: len=0 gives no busy, no pops, no done; the mid-transfer start leaves the original length/address unchanged.
6. Reset mid-write:
   - Stimulus: i_reset_n low during WRITE with i_busy=1.
   - Response: o_request and o_dma_busy drop immediately (asynchronously); a new start after reset runs cleanly from byte 0.
   - With USB_DEBUG_DMA_ABORT_EN: abort in FILL after 2 bytes gives IDLE with no write and no done.
